// File: rtl/instr_buffer_pkg.sv
// -----------------------------------------------------------------------------
// instr_buf_pkg
// Shared definitions for the banked instruction buffer and the upstream
// activation/parameter write controller. The size defaults live here so that
// both sides agree on the bank-index width.
// -----------------------------------------------------------------------------
package instr_buf_pkg;

    localparam int STREAM_WIDTH = 128;
    localparam int NUM_BANKS    = 16;
    localparam int INSTR_DEPTH  = 8;

    // Buffer life cycle: wait for a configuration, fill every bank, serve reads.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } ibuf_state_t;

endpackage

// File: rtl/instr_buffer_if.sv
// -----------------------------------------------------------------------------
// instr_buffer_if
// Groups the configuration handshake, the instruction write stream, the read
// port, the layer release and the error flags of instr_buffer.
//   master : upstream controller / compute array side (drives requests)
//   slave  : instr_buffer side (drives ready, done, read data and errors)
// -----------------------------------------------------------------------------
interface instr_buffer_if #(
    parameter int STREAM_WIDTH = instr_buf_pkg::STREAM_WIDTH,
    parameter int NUM_BANKS    = instr_buf_pkg::NUM_BANKS,
    parameter int INSTR_DEPTH  = instr_buf_pkg::INSTR_DEPTH,
    parameter int PTR_W        = $clog2(INSTR_DEPTH) + 1
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ADDR_W = $clog2(INSTR_DEPTH);

    // configuration
    logic [PTR_W-1:0]        cfg_words_per_bank;
    logic                    cfg_valid;
    logic                    cfg_ready;
    // instruction write stream
    logic [STREAM_WIDTH-1:0] idata_instr;
    logic                    idata_instr_valid;
    logic [BANK_W-1:0]       instr_bank_counter;
    logic                    idata_instr_ready;
    logic                    instr_fill_done;
    // read port
    logic                    rd_req;
    logic [BANK_W-1:0]       rd_bank;
    logic [ADDR_W-1:0]       rd_addr;
    logic [STREAM_WIDTH-1:0] rd_data;
    logic                    rd_valid;
    // layer control and status
    logic                    instr_release;
    logic                    err_overflow;
    logic                    err_cfg;

    modport master (
        output cfg_words_per_bank, cfg_valid,
        output idata_instr, idata_instr_valid, instr_bank_counter,
        output rd_req, rd_bank, rd_addr,
        output instr_release,
        input  cfg_ready, idata_instr_ready, instr_fill_done,
        input  rd_data, rd_valid,
        input  err_overflow, err_cfg
    );

    modport slave (
        input  cfg_words_per_bank, cfg_valid,
        input  idata_instr, idata_instr_valid, instr_bank_counter,
        input  rd_req, rd_bank, rd_addr,
        input  instr_release,
        output cfg_ready, idata_instr_ready, instr_fill_done,
        output rd_data, rd_valid,
        output err_overflow, err_cfg
    );

endinterface

// File: rtl/instr_buffer_bank_ram.sv
// -----------------------------------------------------------------------------
// instr_bank_ram
// Simple dual-port instruction memory: one write port, one synchronous read
// port with a registered output. The storage array itself is never reset;
// only the read-data register and its valid flag are.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data write port
//   rd_en/rd_addr         read request
//   rd_data/rd_valid      read response, one cycle after rd_en
// -----------------------------------------------------------------------------
module instr_bank_ram #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_p1;
    logic              vld_p1;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ---- stage p1: registered read response ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en) begin
                rd_data_p1 <= mem[rd_addr];
            end
        end
    end

    assign rd_data  = rd_data_p1;
    assign rd_valid = vld_p1;

endmodule

// File: rtl/instr_buffer.sv
// -----------------------------------------------------------------------------
// instr_buffer
// Banked instruction store. After a configuration sets the word count per
// bank, tagged 128-bit instruction words are written to each bank's next free
// slot. When every bank is full, instr_fill_done is raised and the buffer
// serves single-cycle-latency reads until instr_release ends the layer.
// Ports:
//   clk  clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  instr_buffer_if.slave: cfg handshake, write stream, read port,
//        release pulse, sticky error flags
// -----------------------------------------------------------------------------
module instr_buffer #(
    parameter int STREAM_WIDTH = instr_buf_pkg::STREAM_WIDTH,
    parameter int NUM_BANKS    = instr_buf_pkg::NUM_BANKS,
    parameter int INSTR_DEPTH  = instr_buf_pkg::INSTR_DEPTH,
    parameter int PTR_W        = $clog2(INSTR_DEPTH) + 1
) (
    input logic           clk,
    input logic           rst,
    instr_buffer_if.slave bus
);

    import instr_buf_pkg::*;

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ADDR_W = $clog2(INSTR_DEPTH);
    localparam int MEM_AW = BANK_W + ADDR_W;

    ibuf_state_t                     state_q, state_d;
    logic [PTR_W-1:0]                wpb_q;
    logic [NUM_BANKS-1:0][PTR_W-1:0] ptr_q, ptr_d;
    logic                            err_overflow_q, err_cfg_q;

    logic              cfg_legal, cfg_accept, cfg_reject;
    logic              instr_ready;
    logic              wr_fire, wr_ok, wr_drop;
    logic              release_fire, rd_en, all_full;
    logic [BANK_W-1:0] wr_bank;
    logic [PTR_W-1:0]  wr_ptr;
    logic [MEM_AW-1:0] wr_addr, rd_addr;
    logic [STREAM_WIDTH-1:0] rd_data_w;
    logic              rd_valid_w;

    // Status outputs depend on the registered state only.
    assign instr_ready           = (state_q == FILL);
    assign bus.cfg_ready         = (state_q == IDLE);
    assign bus.idata_instr_ready = instr_ready;
    assign bus.instr_fill_done   = (state_q == FULL);
    assign bus.err_overflow      = err_overflow_q;
    assign bus.err_cfg           = err_cfg_q;

    assign cfg_legal  = (bus.cfg_words_per_bank != '0) &&
                        (bus.cfg_words_per_bank <= PTR_W'(INSTR_DEPTH));
    assign cfg_accept = (state_q == IDLE) && bus.cfg_valid && cfg_legal;
    assign cfg_reject = (state_q == IDLE) && bus.cfg_valid && !cfg_legal;

    assign wr_bank = bus.instr_bank_counter;
    assign wr_ptr  = ptr_q[wr_bank];
    assign wr_fire = bus.idata_instr_valid && instr_ready;
    // A bank whose pointer already equals wpb is full: the word is dropped.
    assign wr_ok   = wr_fire && (wr_ptr < wpb_q);
    assign wr_drop = wr_fire && !wr_ok;
    assign wr_addr = {wr_bank, wr_ptr[ADDR_W-1:0]};

    assign release_fire = (state_q == FULL) && bus.instr_release;
    assign rd_en        = (state_q == FULL) && bus.rd_req;
    assign rd_addr      = {bus.rd_bank, bus.rd_addr};

    // Next pointer values; the all-full test looks at them so that the
    // write completing the last bank moves the FSM to FULL on the same edge.
    always_comb begin
        ptr_d = ptr_q;
        if (cfg_accept || release_fire) begin
            ptr_d = '0;
        end else if (wr_ok) begin
            ptr_d[wr_bank] = wr_ptr + PTR_W'(1);
        end
        all_full = 1'b1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (ptr_d[b] != wpb_q) begin
                all_full = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (cfg_accept)            state_d = FILL;
            FILL: if (wr_ok && all_full)     state_d = FULL;
            FULL: if (release_fire)          state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q          <= '0;
            wpb_q          <= '0;
            err_overflow_q <= 1'b0;
            err_cfg_q      <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            if (cfg_accept) begin
                wpb_q <= bus.cfg_words_per_bank;
            end
            if (cfg_reject) begin
                err_cfg_q <= 1'b1;
            end
            if (wr_drop) begin
                err_overflow_q <= 1'b1;
            end
        end
    end

    instr_bank_ram #(
        .DATA_W (STREAM_WIDTH),
        .ADDR_W (MEM_AW)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_ok),
        .wr_addr  (wr_addr),
        .wr_data  (bus.idata_instr),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data_w),
        .rd_valid (rd_valid_w)
    );

    assign bus.rd_data  = rd_data_w;
    assign bus.rd_valid = rd_valid_w;

endmodule

// File: tb/tb_instr_buffer.sv
// -----------------------------------------------------------------------------
// tb_instr_buffer
// Directed stimulus for instr_buffer with a behavioural model of the buffer
// (per-bank word lists, a phase variable, sticky flags) compared against the
// DUT on every falling edge, plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_instr_buffer;

    localparam int SW = 128;
    localparam int NB = 16;
    localparam int ID = 8;
    localparam int PW = 4;

    localparam int P_IDLE = 0;
    localparam int P_FILL = 1;
    localparam int P_FULL = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_buffer_if #(.STREAM_WIDTH(SW), .NUM_BANKS(NB), .INSTR_DEPTH(ID), .PTR_W(PW)) ibus ();

    instr_buffer #(.STREAM_WIDTH(SW), .NUM_BANKS(NB), .INSTR_DEPTH(ID), .PTR_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ibus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ model
    int          m_phase = P_IDLE;
    int          m_wpb   = 0;
    int          m_cnt [NB];
    logic [SW-1:0] m_mem [NB][ID];
    bit          m_wr  [NB][ID];
    bit          m_err_ovf = 1'b0;
    bit          m_err_cfg = 1'b0;
    bit          m_rd_valid = 1'b0;
    logic [SW-1:0] m_rd_data = '0;
    bit          m_rd_known = 1'b1;

    task automatic model_step();
        int  b, a, c;
        bit  every_full;
        if (rst) begin
            m_phase    = P_IDLE;
            m_wpb      = 0;
            for (int i = 0; i < NB; i++) m_cnt[i] = 0;
            m_err_ovf  = 1'b0;
            m_err_cfg  = 1'b0;
            m_rd_valid = 1'b0;
            m_rd_data  = '0;
            m_rd_known = 1'b1;
            return;
        end
        m_rd_valid = 1'b0;
        if (m_phase == P_FULL && ibus.rd_req) begin
            b = int'(ibus.rd_bank);
            a = int'(ibus.rd_addr);
            m_rd_valid = 1'b1;
            m_rd_known = m_wr[b][a];
            m_rd_data  = m_mem[b][a];
        end
        case (m_phase)
            P_IDLE: if (ibus.cfg_valid) begin
                c = int'(ibus.cfg_words_per_bank);
                if (c >= 1 && c <= ID) begin
                    m_wpb = c;
                    for (int i = 0; i < NB; i++) m_cnt[i] = 0;
                    m_phase = P_FILL;
                end else begin
                    m_err_cfg = 1'b1;
                end
            end
            P_FILL: if (ibus.idata_instr_valid) begin
                b = int'(ibus.instr_bank_counter);
                if (m_cnt[b] < m_wpb) begin
                    m_mem[b][m_cnt[b]] = ibus.idata_instr;
                    m_wr[b][m_cnt[b]]  = 1'b1;
                    m_cnt[b]++;
                    every_full = 1'b1;
                    for (int i = 0; i < NB; i++) if (m_cnt[i] != m_wpb) every_full = 1'b0;
                    if (every_full) m_phase = P_FULL;
                end else begin
                    m_err_ovf = 1'b1;
                end
            end
            P_FULL: if (ibus.instr_release) m_phase = P_IDLE;
            default: m_phase = P_IDLE;
        endcase
    endtask

    initial begin
        for (int i = 0; i < NB; i++) begin
            m_cnt[i] = 0;
            for (int j = 0; j < ID; j++) m_wr[i][j] = 1'b0;
        end
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // ---------------------------------------------------------- compare process
    initial begin
        @(posedge rst);
        forever begin
            @(negedge clk);
            check1("cmp_cfg_ready",   ibus.cfg_ready,         m_phase == P_IDLE);
            check1("cmp_instr_ready", ibus.idata_instr_ready, m_phase == P_FILL);
            check1("cmp_fill_done",   ibus.instr_fill_done,   m_phase == P_FULL);
            check1("cmp_rd_valid",    ibus.rd_valid,          m_rd_valid);
            check1("cmp_err_ovf",     ibus.err_overflow,      m_err_ovf);
            check1("cmp_err_cfg",     ibus.err_cfg,           m_err_cfg);
            if (m_rd_known) checkw("cmp_rd_data", ibus.rd_data, m_rd_data);
        end
    end

    // ---------------------------------------------------------------- stimulus
    function automatic logic [SW-1:0] word(input int layer, input int b, input int s);
        logic [31:0] w;
        if (layer == 1 && b == 3 && s == 1) return {16{8'hA5}};
        w = {8'(layer), 8'(b), 8'(s), 8'hC3};
        return {4{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input int v);
        ibus.cfg_words_per_bank = PW'(v);
        ibus.cfg_valid = 1'b1;
        tick();
        ibus.cfg_valid = 1'b0;
    endtask

    task automatic send_word(input int b, input logic [SW-1:0] d);
        ibus.instr_bank_counter = 4'(b);
        ibus.idata_instr = d;
        ibus.idata_instr_valid = 1'b1;
        tick();
        ibus.idata_instr_valid = 1'b0;
    endtask

    task automatic do_read(input int b, input int a);
        ibus.rd_bank = 4'(b);
        ibus.rd_addr = 3'(a);
        ibus.rd_req = 1'b1;
        tick();
        ibus.rd_req = 1'b0;
    endtask

    task automatic pulse_release();
        ibus.instr_release = 1'b1;
        tick();
        ibus.instr_release = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check1({tag, "_cfg_ready"},   ibus.cfg_ready,         1'b1);
        check1({tag, "_instr_ready"}, ibus.idata_instr_ready, 1'b0);
        check1({tag, "_fill_done"},   ibus.instr_fill_done,   1'b0);
        check1({tag, "_rd_valid"},    ibus.rd_valid,          1'b0);
        checkw({tag, "_rd_data"},     ibus.rd_data,           '0);
        check1({tag, "_err_ovf"},     ibus.err_overflow,      1'b0);
        check1({tag, "_err_cfg"},     ibus.err_cfg,           1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc;
        ibus.cfg_words_per_bank = '0;
        ibus.cfg_valid          = 1'b0;
        ibus.idata_instr        = '0;
        ibus.idata_instr_valid  = 1'b0;
        ibus.instr_bank_counter = '0;
        ibus.rd_req             = 1'b0;
        ibus.rd_bank            = '0;
        ibus.rd_addr            = '0;
        ibus.instr_release      = 1'b0;

        #1 rst = 1'b1;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Basic fill: wpb=2, 32 words round-robin
        send_cfg(2);
        check1("t1_enter_fill", ibus.idata_instr_ready, 1'b1);
        for (int i = 0; i < 31; i++) send_word(i % 16, word(1, i % 16, i / 16));
        check1("t1_done_before_last", ibus.instr_fill_done, 1'b0);
        send_word(15, word(1, 15, 1));
        check1("t1_done_after_last", ibus.instr_fill_done, 1'b1);
        check1("t1_ready_after_last", ibus.idata_instr_ready, 1'b0);
        do_read(3, 1);
        check1("t1_rd_valid", ibus.rd_valid, 1'b1);
        checkw("t1_rd_a5", ibus.rd_data, {16{8'hA5}});
        tick();
        check1("t1_rd_pulse", ibus.rd_valid, 1'b0);

        // Release together with a read, then refill with wpb=3
        ibus.rd_bank = 4'd0;
        ibus.rd_addr = 3'd0;
        ibus.rd_req = 1'b1;
        ibus.instr_release = 1'b1;
        tick();
        ibus.rd_req = 1'b0;
        ibus.instr_release = 1'b0;
        check1("t5_rel_rd_valid", ibus.rd_valid, 1'b1);
        checkw("t5_rel_rd_data", ibus.rd_data, {4{32'h010000C3}});
        check1("t5_rel_done_low", ibus.instr_fill_done, 1'b0);
        check1("t5_rel_idle", ibus.cfg_ready, 1'b1);
        send_cfg(3);
        for (int s = 0; s < 3; s++)
            for (int b = 0; b < 16; b++) send_word(b, word(2, b, s));
        check1("t5_layer2_done", ibus.instr_fill_done, 1'b1);
        do_read(7, 2);
        checkw("t5_layer2_rd", ibus.rd_data, {4{32'h020702C3}});
        pulse_release();

        // Overflow: wpb=1, two words to bank 0
        send_cfg(1);
        send_word(0, {4{32'hD1D10001}});
        check1("t2_no_ovf_yet", ibus.err_overflow, 1'b0);
        send_word(0, {4{32'hD2D20002}});
        check1("t2_ovf_set", ibus.err_overflow, 1'b1);
        for (int b = 1; b < 15; b++) send_word(b, word(3, b, 0));
        check1("t2_not_done_before_b15", ibus.instr_fill_done, 1'b0);
        send_word(15, word(3, 15, 0));
        check1("t2_done_after_b15", ibus.instr_fill_done, 1'b1);
        do_read(0, 0);
        checkw("t2_bank0_first_word", ibus.rd_data, {4{32'hD1D10001}});
        pulse_release();

        // Backpressure boundary: valid held for 17 words, wpb=1
        send_cfg(1);
        acc = 0;
        ibus.idata_instr_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            ibus.instr_bank_counter = 4'(k % 16);
            ibus.idata_instr = word(4, k % 16, k / 16);
            if (k == 16) check1("t3_ready_low_17th", ibus.idata_instr_ready, 1'b0);
            if (ibus.idata_instr_ready) acc++;
            tick();
        end
        ibus.idata_instr_valid = 1'b0;
        checkw("t3_accepted", SW'(acc), SW'(16));
        check1("t3_done", ibus.instr_fill_done, 1'b1);
        do_read(5, 0);
        checkw("t3_bank5_rd", ibus.rd_data, {4{32'h040500C3}});
        pulse_release();

        // Illegal configurations, then a legal one
        send_cfg(0);
        check1("t4_err_cfg_zero", ibus.err_cfg, 1'b1);
        check1("t4_idle_after_zero", ibus.cfg_ready, 1'b1);
        send_cfg(9);
        check1("t4_idle_after_nine", ibus.cfg_ready, 1'b1);
        check1("t4_not_fill_after_nine", ibus.idata_instr_ready, 1'b0);
        send_cfg(4);
        check1("t4_fill_after_four", ibus.idata_instr_ready, 1'b1);
        check1("t4_cfg_ready_low", ibus.cfg_ready, 1'b0);
        send_cfg(1);

        // Reset during FILL after 5 words
        for (int b = 0; b < 5; b++) send_word(b, word(5, b, 0));
        check1("t6_partial_not_done", ibus.instr_fill_done, 1'b0);
        #1 rst = 1'b1;
        #1;
        check_reset_values("t6_async_rst");
        tick();
        rst = 1'b0;
        tick();
        send_cfg(1);
        for (int b = 0; b < 16; b++) send_word(b, word(6, b, 0));
        check1("t6_refill_done", ibus.instr_fill_done, 1'b1);
        do_read(9, 0);
        checkw("t6_refill_rd", ibus.rd_data, {4{32'h060900C3}});
        pulse_release();
        check1("t6_back_idle", ibus.cfg_ready, 1'b1);

        // Read and release ignored outside FULL
        do_read(9, 0);
        check1("idle_rd_ignored", ibus.rd_valid, 1'b0);
        pulse_release();
        check1("idle_release_ignored", ibus.cfg_ready, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
